// File: rtl/pc_sequencer.sv
// PC owner for the single-cycle MIPS core: run/halt/single-step control plus
// saturating statistics counters for the display board.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_next_in,
  input  logic             branch_taken,
  input  logic             jmp,
  input  logic             jr,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             step_mode,
  input  logic             go,
  output logic [31:0]      PC,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] jmp_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q;
  logic             go_q;
  logic             go_pend_q, go_pend_d;
  logic [CNT_W-1:0] cycle_q, instr_q, br_q, jmp_q;
  logic             go_rise;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  assign go_rise = go & ~go_q;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_en     = 1'b0;
    state_d   = state_q;
    go_pend_d = go_pend_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          pc_en   = 1'b1;
          state_d = step_mode ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        // halt_req is deliberately ignored here: the advance skips the syscall.
        if ((go_pend_q | go_rise) && !stall) begin
          pc_en     = 1'b1;
          go_pend_d = 1'b0;
          state_d   = step_mode ? ST_HALT : ST_RUN;
        end else if (go_rise) begin
          go_pend_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      go_q      <= 1'b0;
      go_pend_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
      br_q      <= '0;
      jmp_q     <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      go_pend_q <= go_pend_d;
      if (pc_en) pc_q <= pc_next_in;
      cycle_q   <= sat_inc(cycle_q, state_q == ST_RUN);
      instr_q   <= sat_inc(instr_q, pc_en);
      br_q      <= sat_inc(br_q, pc_en & branch_taken);
      jmp_q     <= sat_inc(jmp_q, pc_en & (jmp | jr));
    end
  end

  assign PC        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
  assign br_cnt    = br_q;
  assign jmp_cnt   = jmp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: a table of per-cycle stimulus and
// expected post-edge state, plus a saturation sequence on a 4-bit-counter build.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst, branch_taken, jmp, jr, halt_req, stall, step_mode, go;
  logic [31:0] pc_next_in, pc;
  logic        pc_en, halted;
  logic [31:0] cycle_cnt, instr_cnt, br_cnt, jmp_cnt;

  pc_sequencer u_dut (
    .clk(clk), .rst(rst), .pc_next_in(pc_next_in), .branch_taken(branch_taken),
    .jmp(jmp), .jr(jr), .halt_req(halt_req), .stall(stall),
    .step_mode(step_mode), .go(go), .PC(pc), .pc_en(pc_en), .halted(halted),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .br_cnt(br_cnt),
    .jmp_cnt(jmp_cnt)
  );

  // Saturation instance: 4-bit counters, non-zero reset PC
  logic        s_rst, s_br, s_jmp;
  logic [31:0] s_nxt, s_pc;
  logic        s_pc_en, s_halted;
  logic [3:0]  s_cyc, s_ins, s_brc, s_jmc;

  pc_sequencer #(.RESET_PC(32'h0000_0100), .CNT_W(4)) u_sat (
    .clk(clk), .rst(s_rst), .pc_next_in(s_nxt), .branch_taken(s_br),
    .jmp(s_jmp), .jr(1'b0), .halt_req(1'b0), .stall(1'b0),
    .step_mode(1'b0), .go(1'b0), .PC(s_pc), .pc_en(s_pc_en),
    .halted(s_halted), .cycle_cnt(s_cyc), .instr_cnt(s_ins),
    .br_cnt(s_brc), .jmp_cnt(s_jmc)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctl bits: [7]rst [6]branch_taken [5]jmp [4]jr [3]halt_req [2]stall [1]step_mode [0]go
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] nxt;
    logic [1:0]  exp_en;   // 2'b10 = do not check pc_en
    logic [31:0] exp_pc;
    logic        exp_h;
    int          cyc, ins, brc, jmc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] ctl, input logic [31:0] nxt,
                     input logic [1:0] en, input logic [31:0] epc,
                     input logic eh, input int cyc, input int ins,
                     input int brc, input int jmc);
    vec_t v;
    v.ctl = ctl; v.nxt = nxt; v.exp_en = en; v.exp_pc = epc; v.exp_h = eh;
    v.cyc = cyc; v.ins = ins; v.brc = brc; v.jmc = jmc;
    vecs.push_back(v);
  endtask

  localparam logic [1:0] X = 2'b10;

  initial begin
    rst = 1'b1; branch_taken = 0; jmp = 0; jr = 0; halt_req = 0; stall = 0;
    step_mode = 0; go = 0; pc_next_in = '0;
    s_rst = 1'b1; s_br = 0; s_jmp = 0; s_nxt = '0;

    // Reset, then sequential fetch
    add(8'b1000_0000, 32'h00, X, 32'h00, 0, 0, 0, 0, 0);
    add(8'b1000_0000, 32'h00, X, 32'h00, 0, 0, 0, 0, 0);
    add(8'b0000_0000, 32'h04, 1, 32'h04, 0, 1, 1, 0, 0);
    add(8'b0000_0000, 32'h08, 1, 32'h08, 0, 2, 2, 0, 0);
    add(8'b0000_0000, 32'h0C, 1, 32'h0C, 0, 3, 3, 0, 0);
    add(8'b0000_0000, 32'h10, 1, 32'h10, 0, 4, 4, 0, 0);
    // Syscall halt; halt_req ignored while halted; go rise resumes same cycle
    add(8'b0000_1000, 32'h14, 0, 32'h10, 1, 5, 4, 0, 0);
    add(8'b0000_1000, 32'h14, 0, 32'h10, 1, 5, 4, 0, 0);
    add(8'b0000_0001, 32'h14, 1, 32'h14, 0, 5, 5, 0, 0);
    // Branch / jmp / jr counting, including branch+jr together
    add(8'b0100_0001, 32'h18, 1, 32'h18, 0, 6, 6, 1, 0);
    add(8'b0010_0000, 32'h40, 1, 32'h40, 0, 7, 7, 1, 1);
    add(8'b0101_0000, 32'h80, 1, 32'h80, 0, 8, 8, 2, 2);
    // stall + halt_req together: halt wins, no advance
    add(8'b0000_1100, 32'h84, 0, 32'h80, 1, 9, 8, 2, 2);
    add(8'b0000_0000, 32'h84, 0, 32'h80, 1, 9, 8, 2, 2);
    add(8'b0100_0001, 32'h84, 1, 32'h84, 0, 9, 9, 3, 2);
    add(8'b0000_0101, 32'h88, 0, 32'h84, 0, 10, 9, 3, 2);
    // Single-step: one advance per go rising edge
    add(8'b0000_0011, 32'h88, 1, 32'h88, 1, 11, 10, 3, 2);
    add(8'b0000_0011, 32'h8C, 0, 32'h88, 1, 11, 10, 3, 2);
    add(8'b0000_0010, 32'h8C, 0, 32'h88, 1, 11, 10, 3, 2);
    add(8'b0000_0011, 32'h8C, 1, 32'h8C, 1, 11, 11, 3, 2);
    add(8'b0000_0011, 32'h90, 0, 32'h8C, 1, 11, 11, 3, 2);
    add(8'b0000_0010, 32'h90, 0, 32'h8C, 1, 11, 11, 3, 2);
    add(8'b0001_0011, 32'h90, 1, 32'h90, 1, 11, 12, 3, 3);
    // go rise under stall is remembered, fires on first unstalled cycle
    add(8'b0000_0110, 32'h94, 0, 32'h90, 1, 11, 12, 3, 3);
    add(8'b0000_0111, 32'h94, 0, 32'h90, 1, 11, 12, 3, 3);
    add(8'b0000_0111, 32'h94, 0, 32'h90, 1, 11, 12, 3, 3);
    add(8'b0000_0110, 32'h94, 0, 32'h90, 1, 11, 12, 3, 3);
    add(8'b0000_0000, 32'h94, 1, 32'h94, 0, 11, 13, 3, 3);
    add(8'b0000_0000, 32'h98, 1, 32'h98, 0, 12, 14, 3, 3);
    // Pending go was consumed: halting again must not auto-advance
    add(8'b0000_1000, 32'h9C, 0, 32'h98, 1, 13, 14, 3, 3);
    add(8'b0000_0000, 32'h9C, 0, 32'h98, 1, 13, 14, 3, 3);
    // Reset while halted with a pending go
    add(8'b0000_0101, 32'h9C, 0, 32'h98, 1, 13, 14, 3, 3);
    add(8'b1000_0001, 32'h200, X, 32'h00, 0, 0, 0, 0, 0);
    add(8'b0000_1001, 32'h04, 0, 32'h00, 1, 1, 0, 0, 0);
    add(8'b0000_0001, 32'h04, 0, 32'h00, 1, 1, 0, 0, 0);
    add(8'b0000_0000, 32'h04, 0, 32'h00, 1, 1, 0, 0, 0);
    // Low PC bits pass through verbatim
    add(8'b0000_0001, 32'h123, 1, 32'h123, 0, 1, 1, 0, 0);
    add(8'b0000_0000, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 2, 2, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      {rst, branch_taken, jmp, jr, halt_req, stall, step_mode, go} = vecs[i].ctl;
      pc_next_in = vecs[i].nxt;
      #1;
      if (vecs[i].exp_en != X)
        check($sformatf("v%0d pc_en", i), {31'b0, pc_en}, {31'b0, vecs[i].exp_en[0]});
      @(posedge clk);
      #1;
      n_vec++;
      check($sformatf("v%0d PC", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_h});
      check($sformatf("v%0d cycle_cnt", i), cycle_cnt, vecs[i].cyc);
      check($sformatf("v%0d instr_cnt", i), instr_cnt, vecs[i].ins);
      check($sformatf("v%0d br_cnt", i), br_cnt, vecs[i].brc);
      check($sformatf("v%0d jmp_cnt", i), jmp_cnt, vecs[i].jmc);
    end

    // Saturation sequence on the 4-bit build
    @(negedge clk); s_rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    check("sat reset PC", s_pc, 32'h100);
    check("sat reset cyc", {28'b0, s_cyc}, 32'd0);
    check("sat reset halted", {31'b0, s_halted}, 32'd0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      s_rst = 1'b0; s_br = 1'b1; s_jmp = 1'b1; s_nxt = 32'h100 + 32'(k) * 4;
      @(posedge clk); #1;
      if (k == 14 || k == 15 || k == 18) begin
        n_vec++;
        check($sformatf("sat%0d PC", k), s_pc, 32'h100 + 32'(k) * 4);
        check($sformatf("sat%0d cyc", k), {28'b0, s_cyc}, (k > 15) ? 32'd15 : 32'(k));
        check($sformatf("sat%0d ins", k), {28'b0, s_ins}, (k > 15) ? 32'd15 : 32'(k));
        check($sformatf("sat%0d br", k), {28'b0, s_brc}, (k > 15) ? 32'd15 : 32'(k));
        check($sformatf("sat%0d jmp", k), {28'b0, s_jmc}, (k > 15) ? 32'd15 : 32'(k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register of the single-cycle MIPS core and decides, cycle by cycle, whether it loads the next-PC value from the next-PC datapath.
- Implements run / halt / single-step control: syscall halt, resume via a go pushbutton, and a stall hold.
- Keeps saturating statistics counters (cycles, instructions, taken branches, jumps) for the display board.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- pc_next_in  input  32  next PC from the next-PC datapath (branch/jr/jmp/PC+4 already resolved).
- branch_taken  input  1  current instruction is a taken conditional branch.
- jmp  input  1  current instruction is j/jal.
- jr  input  1  current instruction is jr.
- halt_req  input  1  current instruction is a halting syscall.
- stall  input  1  hold PC this cycle (memory or hazard wait).
- step_mode  input  1  1 = single-step: halt after every executed instruction.
- go  input  1  level from debounced button; a rising edge requests resume or step.
- PC  output  32  current PC.
- pc_en  output  1  combinational; 1 in the cycle PC loads pc_next_in.
- halted  output  1  registered; 1 while in HALT.
- cycle_cnt  output  CNT_W  cycles spent in RUN.
- instr_cnt  output  CNT_W  instructions retired (PC advances).
- br_cnt  output  CNT_W  advances with branch_taken=1.
- jmp_cnt  output  CNT_W  advances with jmp=1 or jr=1.

Behaviour:
- Reset values when rst=1 at an edge: PC=RESET_PC, state=RUN, halted=0, all counters=0, go_q=0, go_pend=0. Reset overrides everything, including mid-halt and pending go.
- Edge detect: go_q registers go each cycle. go_rise = go & ~go_q.
- go_pend:
  - Set by go_rise while in HALT.
  - Cleared when consumed by an advance.
  - go_rise while in RUN is ignored.
- States: RUN, HALT (2-bit encoding; halted = state==HALT).
- RUN, evaluated in priority order:
  1. halt_req=1: pc_en=0, next state HALT, PC holds (stays at the syscall). This wins over stall and step_mode.
  2. stall=1: pc_en=0, stay RUN, PC holds.
  3. Otherwise: pc_en=1, PC<=pc_next_in. Next state is HALT if step_mode=1, else RUN.
- HALT:
  - Advance condition: (go_pend | go_rise) & ~stall.
  - On advance: pc_en=1, PC<=pc_next_in (steps past the syscall or the stepped instruction), go_pend<=0. Next state is HALT if step_mode=1, else RUN.
  - halt_req is ignored in HALT; the advance itself skips the syscall.
  - Stall with a pending go: no advance, go_pend is held, and the advance fires on the first cycle stall=0.
- Counters (all saturate at all-ones, never wrap):
  - cycle_cnt increments every cycle with state==RUN, including stalled and halt_req cycles.
  - instr_cnt increments on every pc_en=1.
  - br_cnt increments on pc_en & branch_taken.
  - jmp_cnt increments on pc_en & (jmp | jr).
  - If branch_taken and jmp are both high on an advance, both br_cnt and jmp_cnt increment.
- Latency:
  - PC updates one edge after pc_en.
  - halted rises on the edge that samples halt_req.
  - A resume advance can occur in the same cycle as go_rise.
- No arithmetic on PC inside this block. pc_next_in is loaded verbatim, so bits [1:0] pass through unchanged.

Test Plan:
1. rst high for 2 cycles, then pc_next_in=PC+4 → PC sequence 0,4,8,12. instr_cnt=3 and cycle_cnt=3 after 3 cycles; halted=0.
2. RUN at PC=0x10 with halt_req=1 → halted=1 next cycle, PC stays 0x10, counters frozen except cycle_cnt (+1 for that cycle). Then go rising with pc_next_in=0x14 → same-cycle pc_en=1, PC=0x14, state RUN.
3. step_mode=1, PC=0 → one advance to 4 then HALT. Each go pulse (low→high) advances exactly once: 8, 12. Holding go high gives no further advance; instr_cnt=3.
4. HALT with go_rise during stall=1 for 3 cycles → PC holds, go_pend=1. First cycle with stall=0: PC=pc_next_in, go_pend=0.
5. RUN, stall=1 and halt_req=1 together → HALT, no advance. Then branch_taken=1 advance → br_cnt+1; jr=1 advance → jmp_cnt+1.
6. Counters preset near all-ones (CNT_W=4 build) → saturate at 15. Assert rst mid-HALT with go_pend=1 → PC=RESET_PC, RUN, all counters 0, no spurious advance.
